// File: rtl/sect233r1_pt_mul_stream_pkg.sv
// rtl/sect233r1_pt_mul_stream_pkg.sv - shared constants, state encoding and sizing helper
package sect233r1_pt_mul_stream_pkg;

  localparam int SECT233_M = 233;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  function automatic int nw_words(input int dw);
    return (SECT233_M + dw - 1) / dw;
  endfunction

endpackage

// File: rtl/sect233r1_word_unpack.sv
// rtl/sect233r1_word_unpack.sv - result buffer, output word counter and last-word flag
module sect233r1_word_unpack
  import sect233r1_pt_mul_stream_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_load,
  input  logic [SECT233_M-1:0] i_x,
  input  logic [SECT233_M-1:0] i_y,
  input  logic                 i_active,
  input  logic                 i_adv,
  output logic [DW-1:0]        o_data,
  output logic                 o_last
);

  localparam int NW   = nw_words(DW);
  localparam int TW   = 2 * NW;
  localparam int CW   = $clog2(TW);
  localparam int PADW = NW * DW - SECT233_M;

  logic [TW*DW-1:0] r_buf;
  logic [CW-1:0]    r_cnt;
  logic             w_end;

  assign w_end = (r_cnt == CW'(TW - 1));

  // clr only rewinds the counter; the buffer contents are deliberately retained
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_buf <= {{PADW{1'b0}}, i_y, {PADW{1'b0}}, i_x};
      r_cnt <= '0;
    end else if (i_active && i_adv) begin
      r_buf <= r_buf >> DW;
      r_cnt <= w_end ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_data = r_buf[DW-1:0];
  assign o_last = i_active && w_end;

endmodule

// File: rtl/sect233r1_pt_mul_stream.sv
// rtl/sect233r1_pt_mul_stream.sv - narrow stream front/back end for the sect233r1 point multiplier
module sect233r1_pt_mul_stream
  import sect233r1_pt_mul_stream_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_s_valid,
  output logic                 o_s_ready,
  input  logic [DW-1:0]        i_s_data,
  output logic                 o_m_valid,
  input  logic                 i_m_ready,
  output logic [DW-1:0]        o_m_data,
  output logic                 o_m_last,
  output logic                 o_busy,
  output logic                 o_core_clr,
  output logic                 o_core_start,
  output logic [SECT233_M-1:0] o_core_d,
  input  logic                 i_core_done,
  input  logic [SECT233_M-1:0] i_core_x,
  input  logic [SECT233_M-1:0] i_core_y
);

  localparam int NW = nw_words(DW);
  localparam int KW = $clog2(NW);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [KW-1:0]        r_k;
  logic [SECT233_M-1:0] r_d;
  logic                 w_s_hs;
  logic                 w_k_end;
  logic                 w_load;
  logic                 w_last;

  assign w_s_hs  = (r_state == ST_LOAD) && i_s_valid;
  assign w_k_end = (r_k == KW'(NW - 1));
  assign w_load  = (r_state == ST_BUSY) && i_core_done && !i_clr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_LOAD;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD:  if (w_s_hs && w_k_end) w_state_nxt = ST_START;
      ST_START: w_state_nxt = ST_BUSY;
      ST_BUSY:  if (i_core_done) w_state_nxt = ST_OUT;
      ST_OUT:   if (i_m_ready && w_last) w_state_nxt = ST_LOAD;
      default:  w_state_nxt = ST_LOAD;
    endcase
    if (i_clr) w_state_nxt = ST_LOAD;
  end

  // Per-bit slice write; bits of the top word beyond the field width have no destination
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_k <= '0;
      r_d <= '0;
    end else if (i_clr) begin
      r_k <= '0;
    end else if (w_s_hs) begin
      r_k <= w_k_end ? '0 : r_k + 1'b1;
      for (int i = 0; i < SECT233_M; i++) begin
        if (r_k == KW'(i / DW)) r_d[i] <= i_s_data[i % DW];
      end
    end
  end

  sect233r1_word_unpack #(.DW(DW)) u_unpack (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (i_clr),
    .i_load   (w_load),
    .i_x      (i_core_x),
    .i_y      (i_core_y),
    .i_active (r_state == ST_OUT),
    .i_adv    (i_m_ready),
    .o_data   (o_m_data),
    .o_last   (w_last)
  );

  assign o_s_ready    = (r_state == ST_LOAD);
  assign o_m_valid    = (r_state == ST_OUT);
  assign o_m_last     = w_last;
  assign o_busy       = (r_state != ST_LOAD);
  assign o_core_clr   = i_clr;
  assign o_core_start = (r_state == ST_START);
  assign o_core_d     = r_d;

endmodule

// File: tb/tb_sect233r1_pt_mul_stream.sv
// tb/tb_sect233r1_pt_mul_stream.sv - directed and randomized bench with a word-level reference model
module tb_sect233r1_pt_mul_stream;

  localparam int DW = 32;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          core_clr;
  logic          core_start;
  logic [232:0]  core_d;
  logic          core_done = 1'b0;
  logic [232:0]  core_x = '0;
  logic [232:0]  core_y = '0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0]  words [NW];
  logic [232:0] rx, ry, dsave;

  always #5 clk = ~clk;

  sect233r1_pt_mul_stream #(.DW(DW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_clr        (clr),
    .i_s_valid    (s_valid),
    .o_s_ready    (s_ready),
    .i_s_data     (s_data),
    .o_m_valid    (m_valid),
    .i_m_ready    (m_ready),
    .o_m_data     (m_data),
    .o_m_last     (m_last),
    .o_busy       (busy),
    .o_core_clr   (core_clr),
    .o_core_start (core_start),
    .o_core_d     (core_d),
    .i_core_done  (core_done),
    .i_core_x     (core_x),
    .i_core_y     (core_y)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [232:0] rand233();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[232:0];
  endfunction

  function automatic logic [232:0] model_d();
    logic [255:0] acc = '0;
    for (int i = 0; i < NW; i++) acc = acc | (256'(words[i]) << (32 * i));
    return acc[232:0];
  endfunction

  function automatic logic [31:0] model_word(input logic [232:0] x, input logic [232:0] y, input int i);
    logic [232:0] v;
    v = (i < NW) ? x : y;
    v = v >> (32 * (i % NW));
    return v[31:0];
  endfunction

  task automatic send_scalar(input bit gaps);
    logic [232:0] exp_d;
    int n;
    exp_d = model_d();
    for (int i = 0; i < NW; i++) begin
      if (gaps && ($urandom % 3 == 0)) begin
        s_valid = 1'b0;
        tick();
      end
      s_valid = 1'b1;
      s_data  = words[i];
      n = 0;
      while (!s_ready && n < 50) begin
        tick();
        n++;
      end
      if (n == 50) chk("s_ready_timeout", 0, 1);
      tick();
    end
    s_valid = 1'b0;
    chk("start_pulse", core_start, 1);
    chk("busy_after_load", busy, 1);
    chk("s_ready_in_start", s_ready, 0);
    chk("core_d", core_d, exp_d);
    tick();
    chk("start_single", core_start, 0);
    chk("busy_in_core_wait", busy, 1);
  endtask

  task automatic core_finish(input logic [232:0] x, input logic [232:0] y);
    repeat ($urandom_range(0, 3)) tick();
    core_x = x;
    core_y = y;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    core_x = rand233();
    core_y = rand233();
    chk("m_valid_after_done", m_valid, 1);
    chk("first_word_x0", m_data, model_word(x, y, 0));
  endtask

  task automatic drain(input logic [232:0] x, input logic [232:0] y, input bit bp);
    int hs = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [31:0] prev = '0;
    while (hs < 2 * NW && cyc < 400) begin
      m_ready = bp ? 1'($urandom % 2) : 1'b1;
      if (stalled) chk("stall_stable", {m_valid, m_data}, {1'b1, prev});
      chk("m_valid_held", m_valid, 1);
      if (m_valid) begin
        if (m_ready) begin
          chk($sformatf("word%0d", hs), m_data, model_word(x, y, hs));
          chk($sformatf("last%0d", hs), m_last, (hs == 2 * NW - 1));
          hs++;
          stalled = 0;
        end else begin
          stalled = 1;
          prev = m_data;
        end
      end
      tick();
      cyc++;
    end
    m_ready = 1'b0;
    chk("handshakes", hs, 2 * NW);
    if (!bp) chk("drain_cycles", cyc, 2 * NW);
    chk("s_ready_after_last", s_ready, 1);
    chk("m_valid_after_last", m_valid, 0);
    chk("busy_after_last", busy, 0);
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_d", core_d, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // stray done while idle is ignored
    core_done = 1'b1;
    core_x = rand233();
    tick();
    core_done = 1'b0;
    chk("idle_done_ignored", {m_valid, busy}, 2'b00);

    // scalar 1, x=1, y=2, no back-pressure
    for (int i = 0; i < NW; i++) words[i] = (i == 0) ? 32'h1 : 32'h0;
    send_scalar(1'b0);
    chk("core_d_one", core_d, 233'h1);
    core_finish(233'h1, 233'h2);
    drain(233'h1, 233'h2, 1'b0);

    // top word all ones: only 9 bits survive; random result with back-pressure
    for (int i = 0; i < NW; i++) words[i] = (i == NW - 1) ? 32'hFFFF_FFFF : 32'h0;
    send_scalar(1'b1);
    chk("core_d_top", {core_d[232:224], core_d[223:0] == 224'h0}, {9'h1FF, 1'b1});
    rx = rand233();
    ry = rand233();
    core_finish(rx, ry);
    drain(rx, ry, 1'b1);

    // back-to-back random transactions
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NW; i++) words[i] = $urandom;
      send_scalar(1'b1);
      rx = rand233();
      ry = rand233();
      core_finish(rx, ry);
      drain(rx, ry, t[0]);
    end

    // clr while waiting for the core
    for (int i = 0; i < NW; i++) words[i] = $urandom;
    send_scalar(1'b0);
    dsave = model_d();
    tick();
    clr = 1'b1;
    #1;
    chk("core_clr_follows", core_clr, 1);
    tick();
    clr = 1'b0;
    chk("clr_s_ready", s_ready, 1);
    chk("clr_busy", busy, 0);
    core_x = rand233();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("clr_no_output", m_valid, 0);
    tick();
    chk("clr_no_output_later", m_valid, 0);
    chk("clr_keeps_d", core_d, dsave);

    // asynchronous reset during output word 5
    for (int i = 0; i < NW; i++) words[i] = $urandom;
    send_scalar(1'b0);
    rx = rand233();
    ry = rand233();
    core_finish(rx, ry);
    m_ready = 1'b1;
    repeat (5) tick();
    chk("pre_rst_word5", m_data, model_word(rx, ry, 5));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", m_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_m_data", m_data, 0);
    m_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_no_word", m_valid, 0);
    chk("post_rst_ready", s_ready, 1);

    for (int i = 0; i < NW; i++) words[i] = $urandom;
    send_scalar(1'b1);
    rx = rand233();
    ry = rand233();
    core_finish(rx, ry);
    drain(rx, ry, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
